// File: rtl/sym9_rr_scheduler.sv
// Round-robin front end sharing one two-stage popcount/window evaluator among NREQ
// requesters; results return tagged with the requester index under full backpressure.
module sym9_rr_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned N          = 9,
  parameter int unsigned LO_DEFAULT = 3,
  parameter int unsigned HI_DEFAULT = 6,
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW        = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_lo,
  input  logic [CW-1:0]     cfg_hi,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_y,
  output logic [CW-1:0]     rsp_count,
  output logic              busy
);

  // Stage 1: captured vector and requester index
  logic           r_s1_valid;
  logic [N-1:0]   r_s1_data;
  logic [IDW-1:0] r_s1_id;

  // Stage 2: output register
  logic           r_s2_valid;
  logic [CW-1:0]  r_s2_count;
  logic           r_s2_y;
  logic [IDW-1:0] r_s2_id;

  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_lo;
  logic [CW-1:0]  r_hi;
  logic           r_cfg_ack;
  logic           r_cfg_err;

  logic           w_s2_drain;
  logic           w_s1_adv;
  logic           w_accept_ok;
  logic           w_grant;
  logic [IDW-1:0] w_grant_id;
  logic [NREQ-1:0] w_grant_vec;
  logic [IDW-1:0] w_ptr_next;
  logic [N-1:0]   w_grant_data;
  logic [CW-1:0]  w_count;
  logic           w_y;
  logic           w_busy;
  logic           w_cfg_try;
  logic           w_cfg_legal;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  assign w_busy      = r_s1_valid | r_s2_valid;
  assign w_s2_drain  = r_s2_valid & rsp_ready;
  assign w_s1_adv    = r_s1_valid & (~r_s2_valid | w_s2_drain);
  assign w_accept_ok = ~r_s1_valid | w_s1_adv;

  // Scan ptr, ptr+1, ... (mod NREQ) and stop at the first valid requester.
  always_comb begin
    int unsigned v_idx;
    w_grant    = 1'b0;
    w_grant_id = '0;
    v_idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_grant && w_accept_ok && req_valid[v_idx]) begin
        w_grant    = 1'b1;
        w_grant_id = IDW'(v_idx);
      end
    end
  end

  always_comb begin
    w_grant_vec             = '0;
    w_grant_vec[w_grant_id] = w_grant;
  end

  assign req_ready    = w_grant_vec;
  assign w_ptr_next   = IDW'((32'(w_grant_id) + 32'd1) % NREQ);
  assign w_grant_data = req_data[32'(w_grant_id)*N +: N];

  assign w_count = popcount(r_s1_data);
  assign w_y     = (w_count >= r_lo) && (w_count <= r_hi);

  // A window write only lands on an idle evaluator with no grant competing for the cycle.
  assign w_cfg_try   = cfg_we & ~w_busy & ~w_grant;
  assign w_cfg_legal = (cfg_lo <= cfg_hi) && (cfg_hi <= CW'(N));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_count <= '0;
      r_s2_y     <= 1'b0;
      r_s2_id    <= '0;
      r_ptr      <= '0;
      r_lo       <= CW'(LO_DEFAULT);
      r_hi       <= CW'(HI_DEFAULT);
      r_cfg_ack  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_count <= w_count;
        r_s2_y     <= w_y;
        r_s2_id    <= r_s1_id;
      end else if (w_s2_drain) begin
        r_s2_valid <= 1'b0;
      end

      if (w_grant) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_grant_data;
        r_s1_id    <= w_grant_id;
        r_ptr      <= w_ptr_next;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      r_cfg_ack <= w_cfg_try & w_cfg_legal;
      r_cfg_err <= w_cfg_try & ~w_cfg_legal;
      if (w_cfg_try && w_cfg_legal) begin
        r_lo <= cfg_lo;
        r_hi <= cfg_hi;
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_y     = r_s2_y;
  assign rsp_count = r_s2_count;
  assign busy      = w_busy;
  assign cfg_ack   = r_cfg_ack;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_sym9_rr_scheduler.sv
// Directed bench for sym9_rr_scheduler: cycle model of grants/occupancy plus a response
// scoreboard filled at accept time and drained on each response handshake.
module tb_sym9_rr_scheduler;

  localparam int NREQ = 4;
  localparam int N    = 9;
  localparam int IDW  = 2;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_we;
  logic [CW-1:0]     cfg_lo;
  logic [CW-1:0]     cfg_hi;
  logic              cfg_ack;
  logic              cfg_err;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_y;
  logic [CW-1:0]     rsp_count;
  logic              busy;

  always #5 clk = ~clk;

  sym9_rr_scheduler #(
    .NREQ(NREQ), .N(N), .LO_DEFAULT(3), .HI_DEFAULT(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_count(rsp_count), .busy(busy)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic           y;
  } rsp_t;

  rsp_t q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_hs  = 0;

  logic           m_s1, m_s2, m_ack, m_err;
  logic [IDW-1:0] m_ptr;
  logic [CW-1:0]  m_lo, m_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ*N-1:0] pk(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    m_ptr = '0; m_lo = 4'd3; m_hi = 4'd6;
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    cfg_we = 1'b0; cfg_lo = '0; cfg_hi = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive at negedge, check just after, update model, advance to next negedge.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] d, input logic rr,
                      input logic we = 1'b0, input logic [CW-1:0] lo = '0,
                      input logic [CW-1:0] hi = '0);
    logic [NREQ-1:0] exp_rdy;
    logic adv, ok, g, mb, legal;
    int gi;
    logic [N-1:0] gd;
    rsp_t e, ne;
    req_valid = v; req_data = d; rsp_ready = rr;
    cfg_we = we; cfg_lo = lo; cfg_hi = hi;
    #1;
    mb  = m_s1 | m_s2;
    adv = m_s1 & (~m_s2 | rr);
    ok  = ~m_s1 | adv;
    g = 1'b0; gi = 0; exp_rdy = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(m_ptr) + k) % NREQ;
      if (!g && ok && v[idx]) begin g = 1'b1; gi = idx; end
    end
    if (g) exp_rdy[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
    chk("busy", 32'(busy), 32'(mb));
    chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
    if ((req_valid & req_ready) != '0) n_hs++;
    if (rsp_valid && rr) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_count", 32'(rsp_count), 32'(e.cnt));
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
      end
    end
    if (g) begin
      gd     = d[gi*N +: N];
      ne.id  = IDW'(gi);
      ne.cnt = CW'($countones(gd));
      ne.y   = (ne.cnt >= m_lo) && (ne.cnt <= m_hi);
      q.push_back(ne);
      m_ptr = IDW'((gi + 1) % NREQ);
    end
    legal = (lo <= hi) && (hi <= CW'(N));
    m_ack = we & ~mb & ~g & legal;
    m_err = we & ~mb & ~g & ~legal;
    if (m_ack) begin m_lo = lo; m_hi = hi; end
    m_s2 = adv ? 1'b1 : (m_s2 & ~rr);
    m_s1 = g ? 1'b1 : (adv ? 1'b0 : m_s1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q.size() != 0 || m_s1 || m_s2) && budget < 20) begin
      step('0, '0, 1'b1);
      budget++;
    end
    chk("drain_queue_left", 32'(q.size()), 32'd0);
    step('0, '0, 1'b1);
  endtask

  initial begin
    int snap;
    rst_n = 1'b0;
    model_reset();
    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_count", 32'(rsp_count), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // 1: single requests, latency 2
    step(4'b0001, pk(9'h007, '0, '0, '0), 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step(4'b0001, pk(9'h1FF, '0, '0, '0), 1'b1);
    drain();

    // 2: all valid, full throughput
    for (int i = 0; i < 8; i++)
      step(4'hF, pk(9'h00F, 9'h03F, 9'h07F, 9'h001), 1'b1);
    drain();

    // 3: stall with all valid: exactly two accepts
    snap = n_hs;
    for (int i = 0; i < 5; i++)
      step(4'hF, pk(9'h003, 9'h007, 9'h00F, 9'h01F), 1'b0);
    chk("stall_accepts", 32'(n_hs - snap), 32'd2);
    for (int i = 0; i < 4; i++)
      step(4'hF, pk(9'h1F0, 9'h0E0, 9'h100, 9'h0FF), 1'b1);
    drain();

    // 4: window writes while idle
    step('0, '0, 1'b1, 1'b1, 4'd0, 4'd0);
    step(4'b0010, pk('0, 9'h000, '0, '0), 1'b1);
    step(4'b0100, pk('0, '0, 9'h001, '0), 1'b1);
    drain();
    step('0, '0, 1'b1, 1'b1, 4'd5, 4'd2);
    step('0, '0, 1'b1, 1'b1, 4'd0, 4'd10);
    step(4'b1000, pk('0, '0, '0, 9'h000), 1'b1);
    drain();

    // 5: write while busy is dropped silently, retry when idle
    step(4'b0001, pk(9'h001, '0, '0, '0), 1'b1);
    step('0, '0, 1'b1, 1'b1, 4'd1, 4'd1);
    drain();
    step(4'b0001, pk(9'h001, '0, '0, '0), 1'b1);
    drain();
    step('0, '0, 1'b1, 1'b1, 4'd1, 4'd1);
    step(4'b0010, pk('0, 9'h100, '0, '0), 1'b1);
    drain();

    // 6: reset with both stages full
    step(4'hF, pk(9'h003, 9'h007, 9'h00F, 9'h01F), 1'b0);
    step(4'hF, pk(9'h003, 9'h007, 9'h00F, 9'h01F), 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step(4'hF, pk(9'h007, 9'h07F, 9'h0FF, 9'h03F), 1'b1);
    step(4'hF, pk(9'h007, 9'h07F, 9'h0FF, 9'h03F), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
